// File: rtl/alu_mul_ctrl.sv
// Purpose : shift-and-add multiplier controller that borrows a shared ALU to
//           accumulate op_a*op_b (low 32 bits) over N_ITER iteration cycles.
// Latency : start accepted at edge k -> done pulses during cycle k+N_ITER+1.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, op_a, op_b    multiply request and operands (latched on accept)
//   busy, done, result   status, one-cycle completion pulse, held product
//   alu_req              controller owns the shared ALU this cycle
//   alu_op1/op2/funct    operands and function code driven to the ALU
//   alu_res              ALU result; bit 32 is carry (unused here)

`ifndef FN_ADD
`define FN_ADD 6'h20
`endif

module alu_mul_ctrl #(
    parameter int         N_ITER      = 32,
    parameter logic [5:0] FN_ADD_CODE = `FN_ADD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_req,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [5:0]  alu_funct,
    input  logic [32:0] alu_res
);

    localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [31:0]    acc_q;
    logic [31:0]    mcand_q;
    logic [31:0]    mplier_q;
    logic [CW-1:0]  count_q;
    logic [31:0]    result_q;

    logic           last_iter;
    logic [31:0]    step_acc;

    // Carry out of the ALU is meaningless for a modulo-2^32 product.
    logic           unused_carry;
    assign unused_carry = alu_res[32];

    assign last_iter = (count_q == CW'(N_ITER - 1));

    // Accumulator value after this iteration: add the shifted multiplicand
    // only when the current multiplier bit is set.
    assign step_acc = mplier_q[0] ? alu_res[31:0] : acc_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        alu_req   = 1'b0;
        alu_op1   = 32'd0;
        alu_op2   = 32'd0;
        alu_funct = 6'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                busy      = 1'b1;
                alu_req   = 1'b1;
                alu_op1   = acc_q;
                alu_op2   = mcand_q;
                alu_funct = FN_ADD_CODE;
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            count_q  <= '0;
            result_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q    <= 32'd0;
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        count_q  <= '0;
                    end
                end
                ST_ITER: begin
                    acc_q    <= step_acc;
                    mcand_q  <= {mcand_q[30:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[31:1]};
                    count_q  <= count_q + CW'(1);
                    // Capture includes the add performed in this final step.
                    if (last_iter) begin
                        result_q <= step_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Purpose : self-checking bench for alu_mul_ctrl with a behavioural shared ALU.
// Latency : checks done at cycle N_ITER+1 after accept, busy throughout.
// Backpressure: checks that start is ignored while the controller is busy.

`ifndef FN_ADD
`define FN_ADD 6'h20
`endif

module tb_alu_mul_ctrl;

    localparam int N_ITER = 32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [5:0]  alu_funct;
    logic [32:0] alu_res;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    alu_mul_ctrl #(.N_ITER(N_ITER), .FN_ADD_CODE(`FN_ADD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .alu_req   (alu_req),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_funct (alu_funct),
        .alu_res   (alu_res)
    );

    // Shared ALU: adds for the add code, otherwise returns zero.
    assign alu_res = (alu_funct == `FN_ADD) ? ({1'b0, alu_op1} + {1'b0, alu_op2}) : 33'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Every cycle: an idle ALU port must be all zero, and the ALU is owned
    // exactly in the busy-but-not-done cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("alu_req_vs_busy", {31'd0, alu_req}, {31'd0, busy & ~done});
            if (!alu_req) begin
                chk("idle_alu_zero", {alu_funct == 6'd0, alu_op1 == 32'd0, alu_op2 == 32'd0}, 32'd7);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply from IDLE and follow it to completion. A nonzero
    // poke_at drives a 9x9 start request during that ITER cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int poke_at, input string tag);
        int c;
        bit busy_drop;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        c = 1;
        busy_drop = 1'b0;
        while (!done && c < 100) begin
            if (!busy) busy_drop = 1'b1;
            start = (c == poke_at);
            if (start) begin
                op_a = 32'd9;
                op_b = 32'd9;
            end
            step();
            c++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, c, N_ITER + 1);
        chk({tag, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
        chk({tag, "_result"}, result, exp);
        step();
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result_held"}, result, exp);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] prev;
        int          dcnt;

        vecs[0] = '{32'd7,        32'd6,        32'd42};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{32'd0,        32'hFFFFFFFF, 32'h00000000};
        vecs[3] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
        vecs[4] = '{32'h80000000, 32'd2,        32'h00000000};
        vecs[5] = '{32'h0001_0001, 32'h0001_0001, 32'h0002_0001};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_req", {31'd0, alu_req}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        // Idle with start low: nothing moves.
        op_a = 32'd3;
        op_b = 32'd4;
        step();
        step();
        chk("idle_no_start_busy", {31'd0, busy}, 32'd0);
        chk("idle_no_start_result", result, 32'd0);

        foreach (vecs[i]) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));
        end

        // Start during ITER is ignored; the following back-to-back start in
        // the IDLE cycle right after DONE is accepted.
        run_mul(32'd7, 32'd6, 32'd42, 10, "ignore_start");
        run_mul(32'd9, 32'd9, 32'd81, 0, "back_to_back");

        // Randomized operands against the arithmetic reference a*b mod 2^32.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            run_mul(ra, rb, ra * rb, (i % 3 == 0) ? int'($urandom_range(2, 30)) : 0,
                    $sformatf("rnd%0d", i));
        end

        // Result stays put across idle cycles.
        prev = result;
        step();
        step();
        step();
        chk("idle_result_stable", result, prev);

        // Reset mid-operation aborts it and produces no done.
        op_a  = 32'd7;
        op_b  = 32'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_alu_req", {31'd0, alu_req}, 32'd0);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dcnt++;
            step();
        end
        chk("abort_no_done", dcnt, 0);

        // Reset wins over a simultaneous start.
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_over_start", {31'd0, busy}, 32'd0);
        step();
        chk("rst_over_start_idle", {31'd0, busy}, 32'd0);

        // Normal operation resumes after the abort.
        run_mul(32'd12, 32'd12, 32'd144, 0, "post_reset");

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_ctrl.md
ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

Interface
REQ-001 Parameter N_ITER, default 32: number of multiplier bits processed; also the number of ITER cycles.
REQ-002 Parameter FN_ADD_CODE, default `FN_ADD: alu_funct code driven for accumulate steps.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request new multiply; sampled only in IDLE.
REQ-006 op_a  input  32  multiplicand, two's complement or unsigned.
REQ-007 op_b  input  32  multiplier, two's complement or unsigned.
REQ-008 busy  output  1  high whenever state != IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  32  low 32 bits of op_a*op_b; held until next accepted start.
REQ-011 alu_req  output  1  controller owns shared ALU this cycle.
REQ-012 alu_op1  output  32  to ALU op1.
REQ-013 alu_op2  output  32  to ALU op2.
REQ-014 alu_funct  output  6  to ALU alu_funct.
REQ-015 alu_res  input  33  from ALU; bit 32 = carry, bits 31:0 = sum.

Function
REQ-016 FSM states: IDLE, ITER, DONE; encoding free.
REQ-017 IDLE & start=1 at edge: latch mcand<=op_a, mplier<=op_b, acc<=0, count<=0, next=ITER.
REQ-018 IDLE & start=0: stay IDLE, no register change.
REQ-019 start in ITER or DONE: ignored, no effect on operation or latched operands.
REQ-020 ITER, combinational: alu_req=1, alu_op1=acc, alu_op2=mcand, alu_funct=FN_ADD_CODE.
REQ-021 ITER, at edge: acc<=alu_res[31:0] if mplier[0]=1 else unchanged; mcand<=mcand<<1 (zero fill); mplier<=mplier>>1 (logical); count<=count+1.
REQ-022 ITER with count==N_ITER-1 at edge: next=DONE, result<=final acc value (including this step's add).
REQ-023 alu_res[32] (carry) ignored; arithmetic modulo 2^32; signed and unsigned low words identical.
REQ-024 DONE: done=1 for exactly one cycle; next=IDLE unconditionally.
REQ-025 Latency: start accepted at edge k -> ITER cycles k+1..k+N_ITER -> done high during cycle k+N_ITER+1 (cycle 33 for default).
REQ-026 Back-to-back: start high during the cycle after DONE (IDLE) is accepted; minimum issue interval N_ITER+2 cycles.
REQ-027 alu_req=0 in IDLE and DONE; then alu_op1=0, alu_op2=0, alu_funct=0.
REQ-028 result updates only at ITER->DONE transition; stable otherwise.
REQ-029 No early termination; latency fixed regardless of operand values.

Reset
REQ-030 rst_n=0 at any edge, including mid-ITER or DONE: state<=IDLE, acc, mcand, mplier, count, result <= 0.
REQ-031 During and after reset: busy=0, done=0, alu_req=0, alu outputs 0; aborted operation produces no done.
REQ-032 rst_n has priority over start in the same cycle.

Verification
REQ-033 Bench instantiates alu_mul_ctrl with real alu; checks each cycle that alu_req=0 implies alu_op1/op2/funct = 0.
REQ-034 op_a=7, op_b=6, start 1 cycle -> busy for 33 cycles, done pulse at cycle 33, result=42.
REQ-035 op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001; op_a=0, op_b=0xFFFFFFFF -> result=0.
REQ-036 op_a=-3 (0xFFFFFFFD), op_b=5 -> result=0xFFFFFFF1 (-15); op_a=0x80000000, op_b=2 -> result=0.
REQ-037 Start 7x6, assert start again with 9x9 at cycle 10 -> ignored, result=42; then start 9x9 in IDLE -> result=81.
REQ-038 Start 7x6, drop rst_n at cycle 10 for 1 cycle -> busy=0 next cycle, result=0, no done pulse within 40 cycles.
